// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-requester round-robin picker; the last-grant register lives in the arbiter.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic last_i,
  output logic gnt_valid_o,
  output logic gnt_o
);

  port_t last;

  always_comb begin
    last        = port_t'(last_i);
    gnt_valid_o = i_req_i | d_req_i;
    gnt_o       = PORT_I;
    if (i_req_i && d_req_i) begin
      // Contention: hand the port to whoever did not win last time.
      gnt_o = (last == PORT_I) ? PORT_D : PORT_I;
    end else if (d_req_i) begin
      gnt_o = PORT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency single-ported memory between the fetch (I) and
// data (D) ports; registered responses, one-cycle done pulses, stall outputs.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  i_valid_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  output logic                  i_done_o,
  output logic [DATA_WIDTH-1:0] i_rdata_o,
  input  logic                  d_valid_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  input  logic [2:0]            d_funct3_i,
  output logic                  d_done_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  stall_f_o,
  output logic                  stall_m_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [2:0]            mem_funct3_o,
  input  logic                  mem_rdy_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  arb_state_t            state_q, state_d;
  port_t                 last_q, last_d;
  logic                  req_we_q, req_we_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
  logic [2:0]            req_funct3_q, req_funct3_d;
  logic                  i_done_q, i_done_d;
  logic                  d_done_q, d_done_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic i_elig, d_elig;
  logic gnt_valid, gnt;

  // The done pulse masks its own port so a held valid is not served twice.
  assign i_elig = i_valid_i & ~i_done_q;
  assign d_elig = d_valid_i & ~d_done_q;

  rr_pick2 u_pick (
    .i_req_i    (i_elig),
    .d_req_i    (d_elig),
    .last_i     (last_q),
    .gnt_valid_o(gnt_valid),
    .gnt_o      (gnt)
  );

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    req_we_d     = req_we_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    req_funct3_d = req_funct3_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          if (port_t'(gnt) == PORT_D) begin
            state_d      = BUSY_D;
            last_d       = PORT_D;
            req_we_d     = d_we_i;
            req_addr_d   = d_addr_i;
            req_wdata_d  = d_wdata_i;
            req_funct3_d = d_funct3_i;
          end else begin
            state_d      = BUSY_I;
            last_d       = PORT_I;
            req_we_d     = 1'b0;
            req_addr_d   = i_addr_i;
            req_wdata_d  = '0;
            req_funct3_d = FUNCT3_WORD;
          end
        end
      end
      BUSY_I: begin
        if (mem_rdy_i) begin
          state_d   = IDLE;
          i_done_d  = 1'b1;
          i_rdata_d = mem_rdata_i;
        end
      end
      BUSY_D: begin
        if (mem_rdy_i) begin
          state_d  = IDLE;
          d_done_d = 1'b1;
          if (!req_we_q) begin
            d_rdata_d = mem_rdata_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      last_q       <= PORT_I;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_funct3_q <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      req_we_q     <= req_we_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      req_funct3_q <= req_funct3_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign mem_req_o    = (state_q != IDLE);
  assign mem_we_o     = mem_req_o & req_we_q;
  assign mem_addr_o   = req_addr_q;
  assign mem_wdata_o  = req_wdata_q;
  assign mem_funct3_o = req_funct3_q;

  assign i_done_o  = i_done_q;
  assign d_done_o  = d_done_q;
  assign i_rdata_o = i_rdata_q;
  assign d_rdata_o = d_rdata_q;
  assign stall_f_o = i_valid_i & ~i_done_q;
  assign stall_m_o = d_valid_i & ~d_done_q;

endmodule
